// File: rtl/pulse_interval_meter.sv
// pulse_interval_meter: measures the clock-cycle interval between consecutive
// debounced pulses, counts pulses, flags loss of signal after TIMEOUT idle
// cycles, and buffers intervals in a show-ahead FIFO with a valid/ready port.
//
// Ports:
//   clk, rst_n   - clock (rising edge), asynchronous active-low reset
//   pulse_in     - single-cycle pulse strobe; every high cycle is one pulse
//   clear        - synchronous clear, highest priority
//   meas_data    - interval at FIFO head (0 when empty)
//   meas_valid   - FIFO not empty
//   meas_ready   - consumer pops the head when meas_valid && meas_ready
//   pulse_count  - pulses since reset/clear, wraps modulo 2^16
//   timeout      - high while no pulse has arrived within TIMEOUT cycles
//   overflow     - sticky: an interval was dropped on a full FIFO
module pulse_interval_meter #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_in,
  input  logic             clear,
  output logic [CNT_W-1:0] meas_data,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [15:0]      pulse_count,
  output logic             timeout,
  output logic             overflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MEAS = 2'd1;
  localparam logic [1:0] S_TMO  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] head_q, head_d;
  logic             valid_q, valid_d;
  logic [15:0]      pulse_count_q, pulse_count_d;
  logic             timeout_q, timeout_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] mem_q [FIFO_DEPTH];

  logic push_c;
  logic push_acc_c;
  logic pop_c;

  // Measurement FSM, FIFO bookkeeping and registered show-ahead head.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    occ_d         = occ_q;
    head_d        = head_q;
    valid_d       = valid_q;
    pulse_count_d = pulse_count_q;
    timeout_d     = timeout_q;
    overflow_d    = overflow_q;
    push_c        = 1'b0;
    push_acc_c    = 1'b0;
    pop_c         = 1'b0;

    if (clear) begin
      state_d       = S_IDLE;
      cnt_d         = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      occ_d         = '0;
      head_d        = '0;
      valid_d       = 1'b0;
      pulse_count_d = '0;
      timeout_d     = 1'b0;
      overflow_d    = 1'b0;
    end else begin
      pulse_count_d = pulse_count_q + 16'(pulse_in);

      case (state_q)
        S_IDLE: begin
          if (pulse_in) begin
            state_d = S_MEAS;
            cnt_d   = CNT_W'(1);
          end
        end
        S_MEAS: begin
          if (pulse_in) begin
            push_c = 1'b1;
            cnt_d  = CNT_W'(1);
          end else if (cnt_q == TO_VAL) begin
            state_d   = S_TMO;
            timeout_d = 1'b1;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_TMO: begin
          // Interval spanning a signal loss is meaningless: restart only.
          if (pulse_in) begin
            state_d   = S_MEAS;
            cnt_d     = CNT_W'(1);
            timeout_d = 1'b0;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase

      pop_c      = valid_q && meas_ready;
      // A simultaneous pop frees the slot, so a full FIFO still accepts.
      push_acc_c = push_c && ((occ_q != OCC_FULL) || pop_c);
      if (push_c && !push_acc_c) begin
        overflow_d = 1'b1;
      end

      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push_acc_c) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      occ_d   = occ_q + OCC_W'(push_acc_c) - OCC_W'(pop_c);
      valid_d = (occ_d != '0);

      // Next head: the slot being written this cycle bypasses the memory.
      if (occ_d == '0) begin
        head_d = '0;
      end else if (push_acc_c && (rd_ptr_d == wr_ptr_q)) begin
        head_d = cnt_q;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      occ_q         <= '0;
      head_q        <= '0;
      valid_q       <= 1'b0;
      pulse_count_q <= '0;
      timeout_q     <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      occ_q         <= occ_d;
      head_q        <= head_d;
      valid_q       <= valid_d;
      pulse_count_q <= pulse_count_d;
      timeout_q     <= timeout_d;
      overflow_q    <= overflow_d;
    end
  end

  // FIFO storage; contents are only meaningful between rd and wr pointers.
  always_ff @(posedge clk) begin
    if (push_acc_c) begin
      mem_q[wr_ptr_q] <= cnt_q;
    end
  end

  assign meas_data   = head_q;
  assign meas_valid  = valid_q;
  assign pulse_count = pulse_count_q;
  assign timeout     = timeout_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_pulse_interval_meter.sv
// Scoreboard bench for pulse_interval_meter: a cycle-indexed reference model
// predicts accepted intervals and status; a monitor compares every cycle.
module tb_pulse_interval_meter;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 1000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             pulse_in;
  logic             clear;
  logic [CNT_W-1:0] meas_data;
  logic             meas_valid;
  logic             meas_ready;
  logic [15:0]      pulse_count;
  logic             timeout;
  logic             overflow;

  pulse_interval_meter #(.CNT_W(CNT_W), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .clear(clear),
    .meas_data(meas_data), .meas_valid(meas_valid), .meas_ready(meas_ready),
    .pulse_count(pulse_count), .timeout(timeout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model state: expected FIFO contents and status.
  int unsigned sb[$];
  int unsigned edge_n;
  bit          have_ref;
  int unsigned t_ref;
  logic [15:0] m_cnt;
  bit          m_to;
  bit          m_ovf;
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    have_ref = 1'b0;
    sb.delete();
    m_cnt = '0;
    m_to  = 1'b0;
    m_ovf = 1'b0;
  endfunction

  // One clock cycle: drive at negedge, advance the model at the posedge.
  task automatic step(input bit p, input bit r, input bit c);
    @(negedge clk);
    pulse_in   = p;
    meas_ready = r;
    clear      = c;
    @(posedge clk);
    edge_n++;
    if (c) begin
      model_reset();
    end else if (p) begin
      m_cnt = m_cnt + 16'd1;
      if (have_ref && (edge_n - t_ref) <= TMO) begin
        if (sb.size() < DEPTH) sb.push_back(edge_n - t_ref);
        else m_ovf = 1'b1;
      end
      have_ref = 1'b1;
      t_ref    = edge_n;
      m_to     = 1'b0;
    end else if (have_ref && (edge_n - t_ref) >= TMO) begin
      m_to = 1'b1;
    end
  endtask

  // Reset pulse that lives entirely between two clock edges.
  task automatic mid_reset();
    @(negedge clk);
    pulse_in = 1'b0;
    clear    = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(meas_valid), 0);
    chk("rst_data", 32'(meas_data), 0);
    chk("rst_count", 32'(pulse_count), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_overflow", 32'(overflow), 0);
    model_reset();
    #1 rst_n = 1'b1;
    @(posedge clk);
    edge_n++;
  endtask

  // Monitor: compare status every cycle, pop the scoreboard on a handshake.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        chk("meas_valid", 32'(meas_valid), 32'(sb.size() != 0));
        chk("meas_data", 32'(meas_data), (sb.size() != 0) ? sb[0] : 0);
        chk("pulse_count", 32'(pulse_count), 32'(m_cnt));
        chk("timeout", 32'(timeout), 32'(m_to));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (sb.size() != 0 && meas_ready && !clear) begin
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    int unsigned prob;
    rst_n      = 1'b1;
    pulse_in   = 1'b0;
    clear      = 1'b0;
    meas_ready = 1'b0;
    edge_n     = 0;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Pulses 7 and 13 cycles apart with the consumer always ready.
    repeat (9) step(0, 1, 0);
    step(1, 1, 0);
    repeat (6) step(0, 1, 0);
    step(1, 1, 0);
    repeat (12) step(0, 1, 0);
    step(1, 1, 0);
    repeat (3) step(0, 1, 0);

    // Signal loss, recovery pulse pushes nothing, then a 5-cycle interval.
    step(1, 1, 0);
    repeat (1010) step(0, 1, 0);
    step(1, 1, 0);
    repeat (4) step(0, 1, 0);
    step(1, 1, 0);
    repeat (3) step(0, 1, 0);
    step(0, 1, 1);

    // Overflow with intervals 3..8 while stalled, then drain in order.
    step(1, 0, 0);
    for (int g = 3; g <= 8; g++) begin
      repeat (g - 1) step(0, 0, 0);
      step(1, 0, 0);
    end
    repeat (8) step(0, 1, 0);
    step(0, 1, 1);

    // Full FIFO: pop and push in the same cycle, no overflow.
    step(1, 0, 0);
    repeat (4) begin
      step(0, 0, 0);
      step(1, 0, 0);
    end
    step(0, 0, 0);
    step(1, 1, 0);
    repeat (6) step(0, 1, 0);

    // Clear coinciding with a pulse on a non-empty FIFO.
    step(1, 0, 0);
    repeat (3) step(0, 0, 0);
    step(1, 0, 0);
    step(1, 0, 1);
    repeat (2) step(0, 1, 0);
    step(1, 1, 0);
    repeat (3) step(0, 1, 0);
    step(1, 1, 0);
    repeat (2) step(0, 1, 0);

    // Reset mid-interval, then a fresh measurement.
    step(1, 1, 0);
    repeat (50) step(0, 1, 0);
    mid_reset();
    repeat (5) step(0, 1, 0);
    step(1, 1, 0);
    repeat (8) step(0, 1, 0);
    step(1, 1, 0);
    repeat (3) step(0, 1, 0);

    // Randomized traffic with varying pulse density and back-pressure.
    for (int seg = 0; seg < 16; seg++) begin
      prob = $urandom_range(1, 60);
      for (int k = 0; k < 250; k++) begin
        step($urandom_range(0, 99) < prob,
             (seg % 4 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0),
             $urandom_range(0, 599) == 0);
      end
    end

    repeat (10) step(0, 1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pulse_interval_meter.md
Name: pulse_interval_meter

Overview:
Sits directly downstream of the PulseTracer debounce stage and consumes its single-cycle pulse_out strobe. It measures the clock-cycle interval between consecutive debounced pulses and counts the total number of pulses. It flags loss of signal when no pulse arrives within a timeout. Measured intervals are buffered in a small show-ahead FIFO and delivered over a valid/ready handshake to the host/register stage.

Parameters:
CNT_W, 16, width of the interval counter and of meas_data; counter saturates at 2^CNT_W-1
FIFO_DEPTH, 4, interval FIFO entries; power of 2, minimum 2
TIMEOUT, 1000, cycles without a pulse before timeout asserts; legal range 2 .. 2^CNT_W-1

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
pulse_in  input  1  debounced pulse strobe from PulseTracer pulse_out; each high cycle is one pulse
clear  input  1  synchronous clear: flushes FIFO, counters, flags and returns to IDLE
meas_data  output  CNT_W  interval at FIFO head, in clock cycles
meas_valid  output  1  FIFO not empty
meas_ready  input  1  consumer accepts the head entry when meas_valid && meas_ready
pulse_count  output  16  total pulses since reset/clear; wraps modulo 2^16
timeout  output  1  registered; high while in TIMEOUT state
overflow  output  1  sticky; an interval was dropped because the FIFO was full

Behaviour:
- Reset (rst_n low, asynchronous) sets: state=IDLE, interval counter=0, FIFO empty, meas_valid=0, meas_data=0, pulse_count=0, timeout=0, overflow=0. Reset may assert at any cycle; all in-flight measurements are discarded.
- clear has priority over every other event in the same cycle, including pulse_in, push and pop. Its effect equals reset but is synchronous.
- States:
  IDLE: no reference pulse seen. On pulse_in, go to MEASURING and load cnt<=1. Nothing is pushed.
  MEASURING: cnt<=cnt+1 each cycle, saturating at 2^CNT_W-1. On pulse_in, push cnt and reload cnt<=1. The pushed value equals t1-t0 for pulses at cycles t0 and t1. If no pulse and cnt==TIMEOUT, go to TIMEOUT.
  TIMEOUT: timeout=1 and cnt is held. On pulse_in, go to MEASURING, load cnt<=1 and clear timeout. Nothing is pushed because the interval is invalid.
- Consecutive high cycles on pulse_in are separate pulses: each pushes an interval of 1.
- pulse_count increments on every pulse_in cycle in every state (except when clear is high) and wraps from 65535 to 0.
- FIFO:
  - Show-ahead: meas_data always shows the head entry and is 0 when empty.
  - Push-to-valid latency: a pulse in cycle t1 into an empty FIFO gives meas_valid=1 and meas_data=interval in cycle t1+1.
  - A pop happens when meas_valid && meas_ready.
  - Push while full with no pop: the entry is dropped, the FIFO is unchanged, and overflow is set (sticky until reset/clear).
  - Push and pop in the same cycle while full: both are accepted, occupancy is unchanged, overflow is not set.
  - Push and pop in the same cycle while empty: the push is accepted, there is no pop because meas_valid was 0.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- meas_data is stable while meas_valid=1 and meas_ready=0.

Test Plan:
- Reset, then pulses at cycles 10, 17, 30 with meas_ready=1 -> meas_data is 7 at cycle 18 and 13 at cycle 31, one valid cycle each; pulse_count=3; timeout=0.
- A single pulse, then no pulse for 1000 cycles (TIMEOUT=1000) -> timeout=1 exactly 1000 cycles after the pulse; the next pulse clears timeout and pushes nothing; a pulse 5 cycles later pushes 5.
- meas_ready=0 with 6 intervals (3,4,5,6,7,8) -> FIFO holds 3,4,5,6 and overflow=1; then meas_ready=1 -> pops 3,4,5,6 in order, meas_valid drops, overflow stays 1 until clear.
- FIFO full and meas_ready=1 in the same cycle as a new pulse -> the head pops, the new interval is accepted, overflow stays 0.
- Assert clear in the same cycle as pulse_in with the FIFO non-empty -> next cycle the FIFO is empty, pulse_count=0, state=IDLE; the following pulse pushes nothing.
- Assert rst_n low mid-interval (cnt=50) for a partial cycle -> all outputs 0 immediately; the first two pulses after release give a correct fresh interval.
